test_vector_sequencer: RTL and testbench

Synthesizable, parametrised self-checking unit-test engine for the unit-test flow. It holds a vector memory of stimulus/expected/mask triples and applies each stimulus to a DUT. After a configurable DUT latency it compares the masked DUT response and accumulates pass/fail status. It is the hardware successor to the file-driven per-unit benches: one instance per DUT (alu, flopr, flopmem, regfile read path, ...), usable in simulation and on FPGA.

---
 rtl/test_vector_sequencer.sv | 177 +++++++++++++++++
 tb/tb_test_vector_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/test_vector_sequencer.sv
// Self-checking unit-test engine: replays stored stimulus into a DUT and compares
// the masked response against stored expectations after a fixed DUT latency.
module test_vector_sequencer #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 16,
    parameter int LATENCY     = 1,
    parameter int STOP_ON_ERR = 0,
    parameter int ADDR_W      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [WIDTH-1:0]  load_stim,
    input  logic [WIDTH-1:0]  load_exp,
    input  logic [WIDTH-1:0]  load_mask,
    input  logic [ADDR_W:0]   num_vec,
    input  logic              start,
    output logic [WIDTH-1:0]  dut_in,
    input  logic [WIDTH-1:0]  dut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
    output logic              first_err_valid,
    output logic [ADDR_W-1:0] first_err_idx,
    output logic [ADDR_W-1:0] vec_idx,
    output logic [2:0]        dbg_state
);

    // Encoding is visible on dbg_state: IDLE=0 APPLY=1 WAIT=2 CHECK=3 DONE=4.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_APPLY = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int               CNT_W   = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
    localparam logic [ADDR_W:0]  DEPTH_N = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] LAT_C   = CNT_W'(LATENCY);

    logic [WIDTH-1:0]  r_stim_mem [DEPTH];
    logic [WIDTH-1:0]  r_exp_mem  [DEPTH];
    logic [WIDTH-1:0]  r_mask_mem [DEPTH];

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W:0]   r_n;
    logic [CNT_W-1:0]  r_cnt;
    logic [WIDTH-1:0]  r_dut_in;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [ADDR_W:0]   r_err_count;
    logic              r_first_err_valid;
    logic [ADDR_W-1:0] r_first_err_idx;
    logic [ADDR_W-1:0] r_vec_idx;

    logic [WIDTH-1:0]  w_stim;
    logic [WIDTH-1:0]  w_exp;
    logic [WIDTH-1:0]  w_mask;
    logic              w_mismatch;
    logic              w_last;
    logic              w_stop;
    logic              w_start;
    logic [ADDR_W:0]   w_num_clamped;

    // Memory is deliberately outside reset so vectors survive a reset.
    always_ff @(posedge clk) begin
        if (load_en && !r_busy) begin
            r_stim_mem[load_addr] <= load_stim;
            r_exp_mem[load_addr]  <= load_exp;
            r_mask_mem[load_addr] <= load_mask;
        end
    end

    assign w_stim        = r_stim_mem[r_vec_idx];
    assign w_exp         = r_exp_mem[r_vec_idx];
    assign w_mask        = r_mask_mem[r_vec_idx];
    assign w_mismatch    = |((dut_out ^ w_exp) & w_mask);
    assign w_last        = ({1'b0, r_vec_idx} == (r_n - (ADDR_W + 1)'(1)));
    assign w_stop        = w_last || ((STOP_ON_ERR != 0) && w_mismatch);
    assign w_start       = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_num_clamped = (num_vec > DEPTH_N) ? DEPTH_N : num_vec;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start) begin
                    w_state_next = (w_num_clamped == '0) ? S_DONE : S_APPLY;
                end
            end
            S_APPLY: w_state_next = (LATENCY == 0) ? S_CHECK : S_WAIT;
            S_WAIT: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_next = S_CHECK;
                end
            end
            S_CHECK: w_state_next = w_stop ? S_DONE : S_APPLY;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_n               <= '0;
            r_cnt             <= '0;
            r_dut_in          <= '0;
            r_busy            <= 1'b0;
            r_done            <= 1'b0;
            r_pass            <= 1'b0;
            r_err_count       <= '0;
            r_first_err_valid <= 1'b0;
            r_first_err_idx   <= '0;
            r_vec_idx         <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start) begin
                        r_n               <= w_num_clamped;
                        r_err_count       <= '0;
                        r_first_err_valid <= 1'b0;
                        r_first_err_idx   <= '0;
                        r_vec_idx         <= '0;
                        r_done            <= (w_num_clamped == '0);
                        r_pass            <= (w_num_clamped == '0);
                        r_busy            <= (w_num_clamped != '0);
                    end
                end
                S_APPLY: begin
                    r_dut_in <= w_stim;
                    r_cnt    <= LAT_C;
                end
                S_WAIT: r_cnt <= r_cnt - CNT_W'(1);
                S_CHECK: begin
                    if (w_mismatch) begin
                        r_err_count <= r_err_count + (ADDR_W + 1)'(1);
                        if (!r_first_err_valid) begin
                            r_first_err_valid <= 1'b1;
                            r_first_err_idx   <= r_vec_idx;
                        end
                    end
                    if (w_stop) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                        r_pass <= (r_err_count == '0) && !w_mismatch;
                    end else begin
                        r_vec_idx <= r_vec_idx + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign dut_in          = r_dut_in;
    assign busy            = r_busy;
    assign done            = r_done;
    assign pass            = r_pass;
    assign err_count       = r_err_count;
    assign first_err_valid = r_first_err_valid;
    assign first_err_idx   = r_first_err_idx;
    assign vec_idx         = r_vec_idx;
    assign dbg_state       = r_state;

endmodule

// File: tb/tb_test_vector_sequencer.sv
// Bench: four sequencer instances (combinational, flopr, flopr with stop-on-error,
// 3-stage pipe) share the load/start stimulus and are scored against a vector-list model.
module tb_test_vector_sequencer;
    localparam int W     = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int NI    = 4;
    localparam int LAT [NI] = '{0, 1, 1, 3};
    localparam int SOE [NI] = '{0, 0, 1, 0};

    logic          clk = 1'b0;
    logic          reset;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [W-1:0]  load_stim, load_exp, load_mask;
    logic [AW:0]   num_vec;
    logic          start;

    logic [W-1:0]  din [NI];
    logic [W-1:0]  dout [NI];
    logic          busy_o [NI];
    logic          done_o [NI];
    logic          pass_o [NI];
    logic [AW:0]   errc_o [NI];
    logic          fev_o [NI];
    logic [AW-1:0] fei_o [NI];
    logic [AW-1:0] vidx_o [NI];
    logic [2:0]    dbg_o [NI];
    logic [W-1:0]  p1, p2, p3;

    int n_vec  = 0;
    int n_miss = 0;

    logic [W-1:0] m_stim [DEPTH];
    logic [W-1:0] m_exp  [DEPTH];
    logic [W-1:0] m_mask [DEPTH];
    int           e_run [NI], e_err [NI], e_fei [NI], e_last [NI];
    logic         e_fev [NI];
    logic [W-1:0] e_din [NI];

    always #5 clk = ~clk;

    // DUT models: wire, two flops, and a 3-deep flop pipeline.
    assign dout[0] = din[0];
    always @(posedge clk) begin
        dout[1] <= din[1];
        dout[2] <= din[2];
        p1 <= din[3];
        p2 <= p1;
        p3 <= p2;
    end
    assign dout[3] = p3;

    test_vector_sequencer #(.WIDTH(W), .DEPTH(DEPTH), .LATENCY(0), .STOP_ON_ERR(0)) u0 (
        .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
        .load_stim(load_stim), .load_exp(load_exp), .load_mask(load_mask),
        .num_vec(num_vec), .start(start), .dut_in(din[0]), .dut_out(dout[0]),
        .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]), .err_count(errc_o[0]),
        .first_err_valid(fev_o[0]), .first_err_idx(fei_o[0]), .vec_idx(vidx_o[0]),
        .dbg_state(dbg_o[0]));
    test_vector_sequencer #(.WIDTH(W), .DEPTH(DEPTH), .LATENCY(1), .STOP_ON_ERR(0)) u1 (
        .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
        .load_stim(load_stim), .load_exp(load_exp), .load_mask(load_mask),
        .num_vec(num_vec), .start(start), .dut_in(din[1]), .dut_out(dout[1]),
        .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]), .err_count(errc_o[1]),
        .first_err_valid(fev_o[1]), .first_err_idx(fei_o[1]), .vec_idx(vidx_o[1]),
        .dbg_state(dbg_o[1]));
    test_vector_sequencer #(.WIDTH(W), .DEPTH(DEPTH), .LATENCY(1), .STOP_ON_ERR(1)) u2 (
        .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
        .load_stim(load_stim), .load_exp(load_exp), .load_mask(load_mask),
        .num_vec(num_vec), .start(start), .dut_in(din[2]), .dut_out(dout[2]),
        .busy(busy_o[2]), .done(done_o[2]), .pass(pass_o[2]), .err_count(errc_o[2]),
        .first_err_valid(fev_o[2]), .first_err_idx(fei_o[2]), .vec_idx(vidx_o[2]),
        .dbg_state(dbg_o[2]));
    test_vector_sequencer #(.WIDTH(W), .DEPTH(DEPTH), .LATENCY(3), .STOP_ON_ERR(0)) u3 (
        .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
        .load_stim(load_stim), .load_exp(load_exp), .load_mask(load_mask),
        .num_vec(num_vec), .start(start), .dut_in(din[3]), .dut_out(dout[3]),
        .busy(busy_o[3]), .done(done_o[3]), .pass(pass_o[3]), .err_count(errc_o[3]),
        .first_err_valid(fev_o[3]), .first_err_idx(fei_o[3]), .vec_idx(vidx_o[3]),
        .dbg_state(dbg_o[3]));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string where);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("%s.i%0d.state", where, k), 64'(dbg_o[k]), 64'd0);
            check($sformatf("%s.i%0d.busy", where, k), 64'(busy_o[k]), 64'd0);
            check($sformatf("%s.i%0d.done", where, k), 64'(done_o[k]), 64'd0);
            check($sformatf("%s.i%0d.pass", where, k), 64'(pass_o[k]), 64'd0);
            check($sformatf("%s.i%0d.errc", where, k), 64'(errc_o[k]), 64'd0);
            check($sformatf("%s.i%0d.fev", where, k), 64'(fev_o[k]), 64'd0);
            check($sformatf("%s.i%0d.fei", where, k), 64'(fei_o[k]), 64'd0);
            check($sformatf("%s.i%0d.vidx", where, k), 64'(vidx_o[k]), 64'd0);
            check($sformatf("%s.i%0d.din", where, k), 64'(din[k]), 64'd0);
        end
    endtask

    task automatic load(input int addr, input logic [W-1:0] s, input logic [W-1:0] e,
                        input logic [W-1:0] m);
        @(posedge clk); #1;
        load_en = 1'b1; load_addr = AW'(addr);
        load_stim = s; load_exp = e; load_mask = m;
        m_stim[addr] = s; m_exp[addr] = e; m_mask[addr] = m;
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    // Walk the vector list: each instance runs until its last vector or first error.
    task automatic model_run(input int n_req);
        int  n_eff;
        logic mm;
        n_eff = (n_req > DEPTH) ? DEPTH : n_req;
        for (int k = 0; k < NI; k++) begin
            e_run[k] = 0; e_err[k] = 0; e_fev[k] = 1'b0; e_fei[k] = 0; e_last[k] = 0;
            for (int i = 0; i < n_eff; i++) begin
                e_run[k]++;
                e_last[k] = i;
                mm = ((m_stim[i] ^ m_exp[i]) & m_mask[i]) != '0;
                if (mm) begin
                    e_err[k]++;
                    if (!e_fev[k]) begin e_fev[k] = 1'b1; e_fei[k] = i; end
                    if (SOE[k] != 0) break;
                end
            end
            if (e_run[k] > 0) e_din[k] = m_stim[e_last[k]];
        end
    endtask

    // mode 0: plain run; 1: load and start pulses mid-run; 2: reset mid-run.
    task automatic run(input string tag, input int n_req, input int mode);
        int  done_cyc [NI];
        bit  all_done;
        model_run(n_req);
        @(posedge clk); #1;
        num_vec = (AW + 1)'(n_req); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < NI; k++) done_cyc[k] = -1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (c == 0)
                for (int k = 0; k < NI; k++)
                    check($sformatf("%s.i%0d.busy0", tag, k), 64'(busy_o[k]), 64'(e_run[k] > 0));
            for (int k = 0; k < NI; k++)
                if (done_cyc[k] < 0 && done_o[k]) done_cyc[k] = c;
            if (mode == 1 && c == 3) begin
                start = 1'b1; load_en = 1'b1; load_addr = '0;
                load_stim = $urandom; load_exp = $urandom; load_mask = '1;
            end
            if (mode == 1 && c == 4) begin start = 1'b0; load_en = 1'b0; end
            if (mode == 2 && c == 2) reset = 1'b1;
            if (mode == 2 && c == 3) begin
                reset = 1'b0;
                check_idle({tag, ".rst"});
                for (int k = 0; k < NI; k++) e_din[k] = '0;
                return;
            end
            all_done = 1'b1;
            for (int k = 0; k < NI; k++) if (done_cyc[k] < 0) all_done = 1'b0;
            if (all_done) break;
        end
        for (int k = 0; k < NI; k++) begin
            check($sformatf("%s.i%0d.cycles", tag, k), 64'(done_cyc[k]),
                  64'(e_run[k] * (2 + LAT[k])));
            check($sformatf("%s.i%0d.busy", tag, k), 64'(busy_o[k]), 64'd0);
            check($sformatf("%s.i%0d.pass", tag, k), 64'(pass_o[k]), 64'(e_err[k] == 0));
            check($sformatf("%s.i%0d.errc", tag, k), 64'(errc_o[k]), 64'(e_err[k]));
            check($sformatf("%s.i%0d.fev", tag, k), 64'(fev_o[k]), 64'(e_fev[k]));
            check($sformatf("%s.i%0d.fei", tag, k), 64'(fei_o[k]), 64'(e_fei[k]));
            check($sformatf("%s.i%0d.vidx", tag, k), 64'(vidx_o[k]), 64'(e_last[k]));
            check($sformatf("%s.i%0d.din", tag, k), 64'(din[k]), 64'(e_din[k]));
        end
    endtask

    initial begin
        logic [W-1:0] s, e, m;
        logic [W-1:0] base [4];
        int           r;
        base[0] = 32'h0; base[1] = 32'h1; base[2] = 32'hFFFF_FFFF; base[3] = 32'hA5A5_A5A5;
        reset = 1'b1; load_en = 1'b0; load_addr = '0; load_stim = '0; load_exp = '0;
        load_mask = '0; num_vec = '0; start = 1'b0;
        for (int k = 0; k < NI; k++) e_din[k] = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_idle("reset");

        for (int i = 0; i < 4; i++) load(i, base[i], base[i], '1);
        run("comb", 4, 0);
        load(2, base[2], base[2] ^ 32'h1, '1);
        run("err2", 4, 0);
        load(2, base[2], base[2] ^ 32'h1, 32'hFFFF_FFFE);
        run("mask2", 4, 0);
        load(2, base[2], base[2], '1);
        load(1, base[1], base[1] ^ 32'h1, '1);
        load(3, base[3], base[3] ^ 32'h8000_0000, '1);
        run("stop", 4, 0);
        run("zero", 0, 0);
        run("rerun", 4, 0);

        for (int round = 0; round < 5; round++) begin
            for (int i = 0; i < DEPTH; i++) begin
                s = $urandom;
                r = $urandom_range(0, 5);
                e = (r < 3) ? s : (s ^ (W'(1) << $urandom_range(0, W - 1)));
                m = (r == 5) ? '0 : (($urandom_range(0, 1) != 0) ? '1 : W'($urandom));
                load(i, s, e, m);
            end
            run($sformatf("rnd%0d", round), $urandom_range(0, 31), 0);
            run($sformatf("full%0d", round), DEPTH + 5, 0);
        end

        run("disturb", 8, 1);
        run("disturb_rerun", 8, 0);
        run("midreset", 8, 2);
        run("after_reset", 8, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
